digi_pattern_src: RTL and testbench



---
 rtl/digi_pattern_src_if.sv | 27 ++
 rtl/digi_pattern_src.sv | 148 ++++++++++++++
 tb/tb_digi_pattern_src.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/digi_pattern_src_if.sv
// Bus interface for digi_pattern_src: duration loading, playback control
// and status/level outputs. The slave modport is the pattern source itself.
interface digi_pattern_src_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
);
   logic                         load_valid;
   logic                         load_ready;
   logic [CNT_W-1:0]             load_dur;
   logic                         clear;
   logic                         start;
   logic                         stop;
   logic                         busy;
   logic                         done;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         y;

   modport slave (
      input  load_valid, load_dur, clear, start, stop,
      output load_ready, busy, done, count, y
   );

   modport master (
      output load_valid, load_dur, clear, start, stop,
      input  load_ready, busy, done, count, y
   );
endinterface

// File: rtl/digi_pattern_src.sv
// digi_pattern_src: clocked digital stimulus source. A table of hold
// durations (in clock cycles) is replayed as a toggling level on y,
// starting from INIT. Durations of 0 are played as 1 cycle.
//
// Build option: define DIGI_PATTERN_SRC_REPEAT_EN to loop the pattern
// continuously (y reloads INIT on each wrap, done pulses per wrap) until
// stop or reset. Without it playback is one-shot and ends in DONE.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | not playing; table may be loaded/cleared, start accepted
// RUN    | replaying table; y toggles at each terminal count
// DONE   | pattern finished (one-shot only); behaves like IDLE
module digi_pattern_src #(
   parameter int   DEPTH = 8,
   parameter int   CNT_W = 16,
   parameter logic INIT  = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   digi_pattern_src_if.slave     bus
);

   localparam int WP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [WP_W-1:0]   wp_q, wp_d;
   logic [IDX_W-1:0]  rp_q, rp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              y_q, y_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  table_q [DEPTH];

   logic              running;
   logic              load_ready_w;
   logic              load_fire;
   logic              last_entry;

   // A zero duration still occupies one cycle so the pattern always advances.
   function automatic logic [CNT_W-1:0] hold_len(input logic [CNT_W-1:0] d);
      return (d == '0) ? CNT_W'(1) : d;
   endfunction

   assign running      = (state_q == S_RUN);
   assign load_ready_w = !running && !bus.start && (wp_q < WP_W'(DEPTH));
   // clear takes precedence: no entry is written in a clear cycle.
   assign load_fire    = bus.load_valid && load_ready_w && !bus.clear;
   assign last_entry   = ((WP_W'(rp_q) + WP_W'(1)) == wp_q);

   // Next-state logic for control, pointers, hold counter and output level.
   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.clear) begin
               wp_d = '0;
            end else if (load_fire) begin
               wp_d = wp_q + WP_W'(1);
            end
            // A clear in the same cycle empties the table, so start is dropped.
            if (bus.start && !bus.clear && (wp_q != '0)) begin
               state_d = S_RUN;
               y_d     = INIT;
               rp_d    = '0;
               cnt_d   = hold_len(table_q[0]);
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_d = S_IDLE;
               y_d     = INIT;
               busy_d  = 1'b0;
            end else if (cnt_q > CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (last_entry) begin
`ifdef DIGI_PATTERN_SRC_REPEAT_EN
               rp_d   = '0;
               cnt_d  = hold_len(table_q[0]);
               y_d    = INIT;
               done_d = 1'b1;
`else
               state_d = S_DONE;
               y_d     = ~y_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end else begin
               y_d   = ~y_q;
               rp_d  = rp_q + IDX_W'(1);
               cnt_d = hold_len(table_q[rp_q + IDX_W'(1)]);
            end
         end
         default: begin
            state_d = S_IDLE;
            y_d     = INIT;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         y_q     <= INIT;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Duration table storage; contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (!rst_i && load_fire) begin
         table_q[wp_q[IDX_W-1:0]] <= bus.load_dur;
      end
   end

   assign bus.load_ready = load_ready_w;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.count      = wp_q;
   assign bus.y          = y_q;

endmodule

// File: tb/tb_digi_pattern_src.sv
// Directed, table-driven bench for digi_pattern_src. Each vector drives the
// inputs for one clock, checks load_ready before the edge and the registered
// outputs after it.
module tb_digi_pattern_src;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;
`ifdef DIGI_PATTERN_SRC_REPEAT_EN
   localparam logic TB_INIT = 1'b1;
`else
   localparam logic TB_INIT = 1'b0;
`endif

   typedef struct {
      logic rst;
      logic lv;
      int   dur;
      logic clr;
      logic st;
      logic sp;
      logic e_rdy;
      logic e_y;
      logic e_busy;
      logic e_done;
      int   e_cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;
   vec_t vq[$];

   digi_pattern_src_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   digi_pattern_src #(.DEPTH(DEPTH), .CNT_W(CNT_W), .INIT(TB_INIT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic lv, input int dur, input logic clr,
                      input logic st, input logic sp, input logic rdy, input logic y,
                      input logic b, input logic d, input int c);
      vec_t v;
      v.rst = r; v.lv = lv; v.dur = dur; v.clr = clr; v.st = st; v.sp = sp;
      v.e_rdy = rdy; v.e_y = y; v.e_busy = b; v.e_done = d; v.e_cnt = c;
      vq.push_back(v);
   endtask

   // Shorthands: ld = offer entry, id = idle cycle, go = start, sp = stop, cl = clear.
   task automatic ld(input int dur, input logic rdy, input logic y, input int c);
      add(0, 1, dur, 0, 0, 0, rdy, y, 0, 0, c);
   endtask
   task automatic id(input logic rdy, input logic y, input logic b, input logic d, input int c);
      add(0, 0, 0, 0, 0, 0, rdy, y, b, d, c);
   endtask
   task automatic go(input logic y, input logic b, input int c);
      add(0, 0, 0, 0, 1, 0, 0, y, b, 0, c);
   endtask
   task automatic sp(input logic rdy, input logic y, input int c);
      add(0, 0, 0, 0, 0, 1, rdy, y, 0, 0, c);
   endtask

   task automatic build_vectors();
`ifdef DIGI_PATTERN_SRC_REPEAT_EN
      // INIT=1, table 2,3: y = 1,1,0,0,0 repeating, done at each wrap.
      ld(2, 1, 1, 1);
      ld(3, 1, 1, 2);
      go(1, 1, 2);                       // E0
      id(0, 1, 1, 0, 2);                 // E1
      id(0, 0, 1, 0, 2);                 // E2
      id(0, 0, 1, 0, 2);                 // E3
      id(0, 0, 1, 0, 2);                 // E4
      id(0, 1, 1, 1, 2);                 // E5 wrap
      id(0, 1, 1, 0, 2);                 // E6
      id(0, 0, 1, 0, 2);                 // E7
      id(0, 0, 1, 0, 2);                 // E8
      id(0, 0, 1, 0, 2);                 // E9
      id(0, 1, 1, 1, 2);                 // E10 wrap
      id(0, 1, 1, 0, 2);                 // E11
      id(0, 0, 1, 0, 2);                 // E12
      sp(0, 1, 2);                       // stop returns y to INIT
      id(1, 1, 0, 0, 2);
`else
      go(0, 0, 0);                       // start with empty table ignored
      sp(1, 0, 0);                       // stop outside RUN: no effect
      ld(3, 1, 0, 1);
      ld(2, 1, 0, 2);
      ld(4, 1, 0, 3);
      go(0, 1, 3);                       // E0
      add(0, 1, 7, 1, 0, 0, 0, 0, 1, 0, 3);  // E1: load/clear ignored in RUN
      add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3);  // E2: start ignored in RUN
      id(0, 1, 1, 0, 3);                 // E3
      id(0, 1, 1, 0, 3);                 // E4
      id(0, 0, 1, 0, 3);                 // E5
      id(0, 0, 1, 0, 3);                 // E6
      id(0, 0, 1, 0, 3);                 // E7
      id(0, 0, 1, 0, 3);                 // E8
      id(0, 1, 0, 1, 3);                 // E9 done
      id(1, 1, 0, 0, 3);                 // E10
      add(0, 1, 9, 1, 0, 0, 1, 1, 0, 0, 0);  // clear beats load
      ld(0, 1, 1, 1);
      ld(0, 1, 1, 2);
      go(0, 1, 2);
      id(0, 1, 1, 0, 2);
      id(0, 0, 0, 1, 2);                 // done on second toggle
      go(0, 1, 2);                       // start during done cycle
      id(0, 1, 1, 0, 2);
      id(0, 0, 0, 1, 2);
      id(1, 0, 0, 0, 2);
      add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= DEPTH; k++) ld(5, 1, 0, k);
      ld(5, 0, 0, DEPTH);                // 9th offer held off
      add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);  // clear while full
      id(1, 0, 0, 0, 0);
      ld(5, 1, 0, 1);
      go(0, 1, 1);
      id(0, 0, 1, 0, 1);
      sp(0, 0, 1);                       // stop 2 cycles after start
      id(1, 0, 0, 0, 1);
      go(0, 1, 1);                       // restart: full 5-cycle hold
      id(0, 0, 1, 0, 1);
      id(0, 0, 1, 0, 1);
      id(0, 0, 1, 0, 1);
      id(0, 0, 1, 0, 1);
      id(0, 1, 0, 1, 1);
      id(1, 1, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      ld(1, 1, 1, 1);
      ld(5, 1, 1, 2);
      go(0, 1, 2);
      id(0, 1, 1, 0, 2);
      id(0, 1, 1, 0, 2);
      sp(0, 0, 2);                       // stop with y=1 returns to INIT
      go(0, 1, 2);
      id(0, 1, 1, 0, 2);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset mid-run
      id(1, 0, 0, 0, 0);
`endif
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_dur   = '0;
      bus.clear      = 1'b0;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      build_vectors();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", -1, int'(bus.load_ready), 1);
      chk("rst_y",     -1, int'(bus.y), int'(TB_INIT));
      chk("rst_busy",  -1, int'(bus.busy), 0);
      chk("rst_done",  -1, int'(bus.done), 0);
      chk("rst_count", -1, int'(bus.count), 0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst            = vq[i].rst;
         bus.load_valid = vq[i].lv;
         bus.load_dur   = CNT_W'(vq[i].dur);
         bus.clear      = vq[i].clr;
         bus.start      = vq[i].st;
         bus.stop       = vq[i].sp;
         #1;
         chk("load_ready", i, int'(bus.load_ready), int'(vq[i].e_rdy));
         @(posedge clk);
         #1;
         chk("y",     i, int'(bus.y),     int'(vq[i].e_y));
         chk("busy",  i, int'(bus.busy),  int'(vq[i].e_busy));
         chk("done",  i, int'(bus.done),  int'(vq[i].e_done));
         chk("count", i, int'(bus.count), vq[i].e_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
